// File: rtl/codec_cfg_seq.sv
// Replays a host-loaded table of 16-bit codec register writes through a local-bus I2C master.
// Build option: define CFG_SEQ_RETRY_EN to retry NACKed entries up to MAX_RETRY times.
module codec_cfg_seq #(
  parameter int         LB_DATA_W    = 32,
  parameter int         LB_ADDR_W    = 8,
  parameter int         NUM_ENTRIES  = 16,
  parameter logic [6:0] DEV_ADDR     = 7'h1A,
  parameter logic [7:0] CLK_DIV      = 8'd250,
  parameter int         MAX_RETRY    = 3,
  parameter int         M_ADDR_REG   = 0,
  parameter int         M_CLKDIV_REG = 1,
  parameter int         M_CONFIG_REG = 2,
  parameter int         M_STATUS_REG = 3,
  parameter int         M_DATA_BASE  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lb_wr_en,
  input  logic                 lb_rd_en,
  input  logic [LB_ADDR_W-1:0] lb_addr,
  input  logic [LB_DATA_W-1:0] lb_wr_data,
  output logic                 lb_wr_valid,
  output logic                 lb_rd_valid,
  output logic [LB_DATA_W-1:0] lb_rd_data,
  output logic                 m_lb_wr_en,
  output logic                 m_lb_rd_en,
  output logic [LB_ADDR_W-1:0] m_lb_addr,
  output logic [LB_DATA_W-1:0] m_lb_wr_data,
  input  logic                 m_lb_rd_valid,
  input  logic [LB_DATA_W-1:0] m_lb_rd_data
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

`ifdef CFG_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_SETUP_DIV = 4'd1;
  localparam logic [3:0] S_SETUP_ADR = 4'd2;
  localparam logic [3:0] S_LOAD_B0   = 4'd3;
  localparam logic [3:0] S_LOAD_B1   = 4'd4;
  localparam logic [3:0] S_KICK      = 4'd5;
  localparam logic [3:0] S_GAP       = 4'd6;
  localparam logic [3:0] S_POLL_RD   = 4'd7;
  localparam logic [3:0] S_POLL_WAIT = 4'd8;
  localparam logic [3:0] S_CHECK     = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;

  localparam logic [LB_ADDR_W-1:0] A_CTRL   = LB_ADDR_W'(0);
  localparam logic [LB_ADDR_W-1:0] A_STATUS = LB_ADDR_W'(1);
  localparam logic [LB_ADDR_W-1:0] A_NUM    = LB_ADDR_W'(2);
  localparam logic [LB_ADDR_W-1:0] A_TBL    = LB_ADDR_W'(16);

  logic [3:0]           state_q, state_d;
  logic [4:0]           idx_q, idx_d;
  logic [4:0]           num_q, num_d;
  logic [1:0]           retry_q, retry_d;
  logic [1:0]           gap_q, gap_d;
  logic [1:0]           abort_cnt_q, abort_cnt_d;
  logic                 abort_pend_q, abort_pend_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 nack_q, nack_d;
  logic [15:0]          tbl_q [NUM_ENTRIES];
  logic [15:0]          tbl_d [NUM_ENTRIES];
  logic                 lb_wr_valid_q, lb_wr_valid_d;
  logic                 lb_rd_valid_q, lb_rd_valid_d;
  logic [LB_DATA_W-1:0] lb_rd_data_q, lb_rd_data_d;
  logic                 m_wr_en_q, m_wr_en_d;
  logic                 m_rd_en_q, m_rd_en_d;
  logic [LB_ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [LB_DATA_W-1:0] m_wr_data_q, m_wr_data_d;

  logic                 ctrl_wr, start, abort, run, busy;
  logic [LB_ADDR_W-1:0] tbl_off;
  logic                 tbl_hit;
  logic [IDX_W-1:0]     tbl_idx;
  logic [15:0]          cur_entry;
  logic [LB_DATA_W-1:0] status;
  logic                 unused_bits;

  assign ctrl_wr   = lb_wr_en && (lb_addr == A_CTRL);
  assign start     = ctrl_wr && lb_wr_data[0];
  assign abort     = ctrl_wr && lb_wr_data[1];
  assign run       = (state_q != S_IDLE);
  assign busy      = run && (state_q != S_DONE);
  assign tbl_off   = lb_addr - A_TBL;
  assign tbl_hit   = (lb_addr >= A_TBL) && (tbl_off < LB_ADDR_W'(NUM_ENTRIES));
  assign tbl_idx   = tbl_off[IDX_W-1:0];
  assign cur_entry = tbl_q[idx_q[IDX_W-1:0]];
  assign unused_bits = ^{lb_wr_data[LB_DATA_W-1:16], m_lb_rd_data[LB_DATA_W-1:2]};

  always_comb begin
    status        = '0;
    status[0]     = busy;
    status[1]     = done_q;
    status[2]     = err_q;
    status[11:8]  = idx_q[3:0];
    status[17:16] = retry_q;
  end

  // Host side: one-cycle acknowledge; table and count are frozen while a sequence runs.
  always_comb begin
    lb_wr_valid_d = lb_wr_en;
    lb_rd_valid_d = lb_rd_en;
    lb_rd_data_d  = '0;
    num_d         = num_q;
    tbl_d         = tbl_q;
    if (lb_rd_en) begin
      if (lb_addr == A_STATUS)   lb_rd_data_d = status;
      else if (lb_addr == A_NUM) lb_rd_data_d = LB_DATA_W'(num_q);
      else if (tbl_hit)          lb_rd_data_d = LB_DATA_W'(tbl_q[tbl_idx]);
    end
    if (lb_wr_en && !run) begin
      if (lb_addr == A_NUM) num_d = lb_wr_data[4:0];
      else if (tbl_hit)     tbl_d[tbl_idx] = lb_wr_data[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    retry_d      = retry_q;
    gap_d        = gap_q;
    abort_cnt_d  = abort_cnt_q;
    abort_pend_d = abort_pend_q;
    done_d       = done_q;
    err_d        = err_q;
    nack_d       = nack_q;
    m_wr_en_d    = 1'b0;
    m_rd_en_d    = 1'b0;
    m_addr_d     = '0;
    m_wr_data_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          done_d  = (num_q == 5'd0);
          err_d   = 1'b0;
          idx_d   = '0;
          retry_d = '0;
          if (num_q != 5'd0) state_d = S_SETUP_DIV;
        end
      end
      S_SETUP_DIV: begin
        m_wr_en_d   = 1'b1;
        m_addr_d    = LB_ADDR_W'(M_CLKDIV_REG);
        m_wr_data_d = LB_DATA_W'(CLK_DIV);
        state_d     = S_SETUP_ADR;
      end
      S_SETUP_ADR: begin
        m_wr_en_d   = 1'b1;
        m_addr_d    = LB_ADDR_W'(M_ADDR_REG);
        m_wr_data_d = LB_DATA_W'({DEV_ADDR, 1'b0});
        state_d     = S_LOAD_B0;
      end
      S_LOAD_B0: begin
        m_wr_en_d   = 1'b1;
        m_addr_d    = LB_ADDR_W'(M_DATA_BASE);
        m_wr_data_d = LB_DATA_W'(cur_entry[15:8]);
        state_d     = S_LOAD_B1;
      end
      S_LOAD_B1: begin
        m_wr_en_d   = 1'b1;
        m_addr_d    = LB_ADDR_W'(M_DATA_BASE + 1);
        m_wr_data_d = LB_DATA_W'(cur_entry[7:0]);
        state_d     = S_KICK;
      end
      S_KICK: begin
        m_wr_en_d   = 1'b1;
        m_addr_d    = LB_ADDR_W'(M_CONFIG_REG);
        m_wr_data_d = LB_DATA_W'(32'h0000_0207);
        gap_d       = '0;
        state_d     = S_GAP;
      end
      // Give the master time to raise busy before the first status read.
      S_GAP: begin
        gap_d = gap_q + 2'd1;
        if (gap_q == 2'd3) state_d = S_POLL_RD;
      end
      S_POLL_RD: begin
        m_rd_en_d   = 1'b1;
        m_addr_d    = LB_ADDR_W'(M_STATUS_REG);
        abort_cnt_d = '0;
        state_d     = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (m_lb_rd_valid) begin
          nack_d  = m_lb_rd_data[1];
          state_d = m_lb_rd_data[0] ? S_POLL_RD : S_CHECK;
        end
      end
      S_CHECK: begin
        if (!nack_q) begin
          idx_d   = idx_q + 5'd1;
          retry_d = '0;
          if (idx_q + 5'd1 == num_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD_B0;
          end
        end else if (RETRY_EN && (retry_q < RETRY_LIM)) begin
          retry_d = retry_q + 2'd1;
          state_d = S_LOAD_B0;
        end else begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort suppresses every further strobe; a read already in flight is drained first.
    if (busy && (abort || abort_pend_q)) begin
      m_wr_en_d   = 1'b0;
      m_rd_en_d   = 1'b0;
      m_addr_d    = '0;
      m_wr_data_d = '0;
      if ((state_q == S_POLL_WAIT) && !m_lb_rd_valid && (abort_cnt_q != 2'd3)) begin
        abort_pend_d = 1'b1;
        abort_cnt_d  = abort_cnt_q + 2'd1;
        state_d      = S_POLL_WAIT;
      end else begin
        abort_pend_d = 1'b0;
        err_d        = 1'b1;
        state_d      = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      num_q         <= '0;
      retry_q       <= '0;
      gap_q         <= '0;
      abort_cnt_q   <= '0;
      abort_pend_q  <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      nack_q        <= 1'b0;
      for (int k = 0; k < NUM_ENTRIES; k++) tbl_q[k] <= '0;
      lb_wr_valid_q <= 1'b0;
      lb_rd_valid_q <= 1'b0;
      lb_rd_data_q  <= '0;
      m_wr_en_q     <= 1'b0;
      m_rd_en_q     <= 1'b0;
      m_addr_q      <= '0;
      m_wr_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      num_q         <= num_d;
      retry_q       <= retry_d;
      gap_q         <= gap_d;
      abort_cnt_q   <= abort_cnt_d;
      abort_pend_q  <= abort_pend_d;
      done_q        <= done_d;
      err_q         <= err_d;
      nack_q        <= nack_d;
      tbl_q         <= tbl_d;
      lb_wr_valid_q <= lb_wr_valid_d;
      lb_rd_valid_q <= lb_rd_valid_d;
      lb_rd_data_q  <= lb_rd_data_d;
      m_wr_en_q     <= m_wr_en_d;
      m_rd_en_q     <= m_rd_en_d;
      m_addr_q      <= m_addr_d;
      m_wr_data_q   <= m_wr_data_d;
    end
  end

  assign lb_wr_valid  = lb_wr_valid_q;
  assign lb_rd_valid  = lb_rd_valid_q;
  assign lb_rd_data   = lb_rd_data_q;
  assign m_lb_wr_en   = m_wr_en_q;
  assign m_lb_rd_en   = m_rd_en_q;
  assign m_lb_addr    = m_addr_q;
  assign m_lb_wr_data = m_wr_data_q;

endmodule
